lsu_bus_master: RTL and testbench

Load/store initiator for the MEM stage. Takes one load or store per instruction from the pipeline. Drives a word-addressed, byte-enabled request/grant/read-valid data-memory bus, and stalls the pipeline until the access completes. Loads are sign- or zero-extended for sub-word sizes. Misaligned accesses are rejected without touching the bus.

---
 rtl/lsu_bus_master.sv | 170 +++++++++++++++++
 tb/tb_lsu_bus_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: MEM-stage load/store initiator on a word-addressed req/gnt/rvalid data bus.
// Define LSU_TRACE_EN to print store-grant and misalignment trace lines in simulation.
module lsu_bus_master #(
    parameter int ADDR_W         = 32,
    parameter int LANE_REPLICATE = 1
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_len,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              addr_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [1:0]  len_q;
    logic        sign_q;
    logic [1:0]  lane_q;

    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] load_ext;

    // Alignment check, byte enables and lane placement of store data for the incoming request
    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = req_wdata;
        case (req_len)
            2'b00: misaligned = |req_addr[1:0];
            2'b01: begin
                misaligned = req_addr[0];
                be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
                if (LANE_REPLICATE != 0)
                    wdata_next = {2{req_wdata[15:0]}};
                else
                    wdata_next = req_addr[1] ? {req_wdata[15:0], 16'h0000}
                                             : {16'h0000, req_wdata[15:0]};
            end
            2'b10: begin
                be_next = 4'b0001 << req_addr[1:0];
                if (LANE_REPLICATE != 0)
                    wdata_next = {4{req_wdata[7:0]}};
                else
                    wdata_next = {24'h000000, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Select the addressed lane of the returned word and extend it to 32 bits
    always_comb begin
        half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (lane_q)
            2'b00:   byte_sel = bus_rdata[7:0];
            2'b01:   byte_sel = bus_rdata[15:8];
            2'b10:   byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        case (len_q)
            2'b01:   load_ext = {{16{sign_q & half_sel[15]}}, half_sel};
            2'b10:   load_ext = {{24{sign_q & byte_sel[7]}}, byte_sel};
            default: load_ext = bus_rdata;
        endcase
    end

    assign addr_err = (state == IDLE) & req_valid & misaligned;
    assign stall    = req_valid & ~addr_err & (state != DONE);

    // Request FSM; request fields are captured only when leaving IDLE
    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= IDLE;
            len_q     <= 2'b00;
            sign_q    <= 1'b0;
            lane_q    <= 2'b00;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0;
            rdata     <= 32'h0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && !misaligned) begin
                        len_q     <= req_len;
                        sign_q    <= req_sign;
                        lane_q    <= req_addr[1:0];
                        bus_req   <= 1'b1;
                        bus_we    <= req_we;
                        bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        bus_be    <= be_next;
                        bus_wdata <= wdata_next;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        if (bus_we) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        rdata <= load_ext;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LSU_TRACE_EN
    logic [31:0] pc_q;

    always_ff @(posedge Clk) begin
        if (reset)
            pc_q <= 32'h0;
        else if (state == IDLE && req_valid && !misaligned)
            pc_q <= req_pc;
    end

    // Simulation-only trace of granted stores and rejected misaligned requests
    always @(posedge Clk) begin
        if (!reset && state == REQ && bus_gnt && bus_we) begin
            if (len_q == 2'b00)
                $display("@%08h: *%08h <= %08h", pc_q, bus_addr, bus_wdata);
            else
                $display("@%08h: *%08h <= %08h be=%h", pc_q, bus_addr, bus_wdata, bus_be);
        end
        if (!reset && addr_err)
            $display("@%08h: misaligned %08h", req_pc, req_addr);
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: directed vectors with a queue-based scoreboard; a monitor checks bus
// requests, completions and misalignment pulses while the driver checks latency and stall.
module tb_lsu_bus_master;

    logic        Clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_len;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        addr_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chkData;
    } busExp_t;

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } doneExp_t;

    busExp_t     busQ[$];
    doneExp_t    doneQ[$];
    logic [31:0] errQ[$];

    lsu_bus_master #(.ADDR_W(32), .LANE_REPLICATE(1)) dut (
        .Clk(Clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_len(req_len), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .stall(stall), .done(done), .rdata(rdata), .addr_err(addr_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic flagUnexpected(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: got an unexpected event, want none", name);
    endtask

    // Drives one aligned request from the IDLE cycle onward and plays the bus responder.
    // Called just after a rising edge; returns just after the edge that leaves DONE.
    task automatic applyStimulus(input string name, input logic we, input logic [1:0] len,
                                 input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int gntDly, input int rvDly, input logic [31:0] busData,
                                 input int expCycles, input int expStall);
        int cycles   = 0;
        int stalls   = 0;
        int reqSeen  = 0;
        int waitSeen = 0;
        bit finished = 0;
        req_valid = 1'b1; req_we = we; req_len = len; req_sign = sign;
        req_addr = addr; req_wdata = wdata; req_pc = 32'h1000 + addr;
        while (!finished && cycles < 100) begin
            @(negedge Clk);
            cycles++;
            if (stall) stalls++;
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'hDEAD_BEEF;
            if (done) begin
                finished = 1;
            end else if (bus_req) begin
                if (!we) bus_rvalid = 1'b1;
                if (reqSeen == gntDly) bus_gnt = 1'b1;
                reqSeen++;
            end else if (!we && reqSeen > 0) begin
                if (waitSeen == rvDly) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = busData;
                end
                waitSeen++;
            end
            @(posedge Clk); #1;
            // Request inputs wander after the IDLE cycle; the DUT must ignore them
            req_addr = addr ^ 32'h0000_0F0C; req_wdata = ~wdata; req_sign = ~sign; req_len = ~len;
        end
        req_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        checkOutput({name, "_done_seen"}, {31'd0, finished}, 32'd1);
        checkOutput({name, "_cycles"}, cycles, expCycles);
        checkOutput({name, "_stall_cycles"}, stalls, expStall);
    endtask

    // One-cycle misaligned request: expects an immediate addr_err and no bus activity
    task automatic applyBad(input string name, input logic [1:0] len, input logic [31:0] addr);
        errQ.push_back(addr);
        req_valid = 1'b1; req_we = 1'b0; req_len = len; req_sign = 1'b0;
        req_addr = addr; req_wdata = 32'h0; req_pc = 32'h2000 + addr;
        @(negedge Clk);
        checkOutput({name, "_addr_err"}, {31'd0, addr_err}, 32'd1);
        checkOutput({name, "_stall"}, {31'd0, stall}, 32'd0);
        @(posedge Clk); #1;
        req_valid = 1'b0;
        @(negedge Clk);
        checkOutput({name, "_err_pulse_end"}, {31'd0, addr_err}, 32'd0);
        checkOutput({name, "_no_bus_req"}, {31'd0, bus_req}, 32'd0);
        @(posedge Clk); #1;
    endtask

    // Monitor: pops expectations whenever the DUT raises a request, completes, or flags misalignment
    initial begin : monitor
        logic     prevReq;
        bit       haveCur;
        busExp_t  cur;
        doneExp_t d;
        prevReq = 1'b0;
        haveCur = 1'b0;
        cur     = '0;
        forever begin
            @(negedge Clk);
            if (reset) begin
                prevReq = 1'b0;
                haveCur = 1'b0;
            end else begin
                if (bus_req && !prevReq) begin
                    if (busQ.size() == 0) begin
                        flagUnexpected("bus_req_rise");
                        haveCur = 1'b0;
                    end else begin
                        cur     = busQ.pop_front();
                        haveCur = 1'b1;
                    end
                end
                if (bus_req && haveCur) begin
                    checkOutput("bus_we", {31'd0, bus_we}, {31'd0, cur.we});
                    checkOutput("bus_addr", bus_addr, cur.addr);
                    checkOutput("bus_be", {28'd0, bus_be}, {28'd0, cur.be});
                    if (cur.chkData) checkOutput("bus_wdata", bus_wdata, cur.wdata);
                end
                prevReq = bus_req;
                if (done) begin
                    if (doneQ.size() == 0) begin
                        flagUnexpected("done_pulse");
                    end else begin
                        d = doneQ.pop_front();
                        if (d.chk) checkOutput("rdata", rdata, d.data);
                    end
                end
                if (addr_err) begin
                    if (errQ.size() == 0) flagUnexpected("addr_err_pulse");
                    else void'(errQ.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_len = 2'b00; req_sign = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(posedge Clk);
        #1;
        @(negedge Clk);
        checkOutput("rst_bus_req", {31'd0, bus_req}, 32'd0);
        checkOutput("rst_bus_we", {31'd0, bus_we}, 32'd0);
        checkOutput("rst_bus_addr", bus_addr, 32'd0);
        checkOutput("rst_bus_be", {28'd0, bus_be}, 32'd0);
        checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_addr_err", {31'd0, addr_err}, 32'd0);
        @(posedge Clk); #1;
        reset = 1'b0;

        busQ.push_back('{1'b1, 32'h0000_312C, 4'b1111, 32'hFFFF_CA20, 1'b1});
        doneQ.push_back('{1'b0, 32'h0});
        applyStimulus("st_word", 1'b1, 2'b00, 1'b0, 32'h0000_312C, 32'hFFFF_CA20, 0, 0, 32'h0, 3, 2);

        busQ.push_back('{1'b1, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 1'b1});
        doneQ.push_back('{1'b0, 32'h0});
        applyStimulus("st_byte", 1'b1, 2'b10, 1'b0, 32'h0000_0103, 32'h0000_00AB, 0, 0, 32'h0, 3, 2);

        busQ.push_back('{1'b0, 32'h0000_0200, 4'b1100, 32'h0, 1'b0});
        doneQ.push_back('{1'b1, 32'hFFFF_8001});
        applyStimulus("ld_half_s", 1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 0, 0, 32'h8001_7FFF, 4, 3);

        busQ.push_back('{1'b0, 32'h0000_0200, 4'b1100, 32'h0, 1'b0});
        doneQ.push_back('{1'b1, 32'h0000_8001});
        applyStimulus("ld_half_u", 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 0, 0, 32'h8001_7FFF, 4, 3);

        busQ.push_back('{1'b0, 32'h0000_0000, 4'b0010, 32'h0, 1'b0});
        doneQ.push_back('{1'b1, 32'hFFFF_FFF5});
        applyStimulus("ld_byte_slow", 1'b0, 2'b10, 1'b1, 32'h0000_0001, 32'h0, 2, 3, 32'h0000_F500, 9, 8);

        busQ.push_back('{1'b1, 32'h0000_0204, 4'b1100, 32'hBEEF_BEEF, 1'b1});
        doneQ.push_back('{1'b0, 32'h0});
        applyStimulus("st_half_hi", 1'b1, 2'b01, 1'b0, 32'h0000_0206, 32'h0000_BEEF, 1, 0, 32'h0, 4, 3);

        busQ.push_back('{1'b0, 32'h0000_0040, 4'b1111, 32'h0, 1'b0});
        doneQ.push_back('{1'b1, 32'h1234_5678});
        applyStimulus("ld_word", 1'b0, 2'b00, 1'b1, 32'h0000_0040, 32'h0, 0, 1, 32'h1234_5678, 5, 4);

        busQ.push_back('{1'b0, 32'h0000_0000, 4'b1000, 32'h0, 1'b0});
        doneQ.push_back('{1'b1, 32'h0000_009A});
        applyStimulus("ld_byte_u3", 1'b0, 2'b10, 1'b0, 32'h0000_0003, 32'h0, 0, 0, 32'h9A00_0000, 4, 3);

        applyBad("bad_word", 2'b00, 32'h0000_0006);
        applyBad("bad_half", 2'b01, 32'h0000_0005);
        applyBad("bad_len11", 2'b11, 32'h0000_0000);

        // Load abandoned by reset while waiting for read data
        busQ.push_back('{1'b0, 32'h0000_0300, 4'b1111, 32'h0, 1'b0});
        req_valid = 1'b1; req_we = 1'b0; req_len = 2'b00; req_sign = 1'b0;
        req_addr = 32'h0000_0300; req_wdata = 32'h0;
        @(posedge Clk); #1;
        @(negedge Clk);
        bus_gnt = 1'b1;
        @(posedge Clk); #1;
        bus_gnt = 1'b0;
        reset = 1'b1;
        @(posedge Clk); #1;
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge Clk);
        checkOutput("wait_rst_bus_req", {31'd0, bus_req}, 32'd0);
        checkOutput("wait_rst_done", {31'd0, done}, 32'd0);
        checkOutput("wait_rst_rdata", rdata, 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk); #1;
            @(negedge Clk);
            checkOutput("late_rvalid_done", {31'd0, done}, 32'd0);
            checkOutput("late_rvalid_rdata", rdata, 32'd0);
        end
        @(posedge Clk); #1;
        bus_rvalid = 1'b0;

        busQ.push_back('{1'b0, 32'h0000_0000, 4'b0100, 32'h0, 1'b0});
        doneQ.push_back('{1'b1, 32'h0000_0042});
        applyStimulus("ld_after_rst", 1'b0, 2'b10, 1'b1, 32'h0000_0002, 32'h0, 0, 0, 32'h0042_0000, 4, 3);

        repeat (2) @(posedge Clk);
        #1;
        checkOutput("busQ_drained", busQ.size(), 32'd0);
        checkOutput("doneQ_drained", doneQ.size(), 32'd0);
        checkOutput("errQ_drained", errQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
